// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC, a shift-register return stack and the
// two-word branch sequencing (opcode word in RUN, address word in TARGET).
module pc_sequencer #(
    parameter int PC_WIDTH    = 12,
    parameter int PC_STEP     = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic [15:0]         instr_word,
    input  logic [2:0]          branch_op,
    input  logic                acc_zero,
    input  logic                acc_neg,
    input  logic                ar_nonzero,
    output logic [PC_WIDTH-1:0] pc,
    output logic                exec_valid,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic {RUN, TARGET} state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_B, OP_BZ, OP_BNZ, OP_BGEZ, OP_BANZ, OP_CALL, OP_RET
    } op_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc_next, pc_inc;
    logic                taken_q, taken_next;
    logic                is_call_q, call_next;
    logic                cond;
    logic                push, pop;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [DEPTH_W-1:0]  depth;
    op_t                 op;

    // Address bits above PC_WIDTH in the target word are don't-care.
    logic unused_instr;
    assign unused_instr = &{1'b0, instr_word};

    assign op         = op_t'(branch_op);
    assign pc_inc     = pc + PC_WIDTH'(PC_STEP);
    assign exec_valid = (state == RUN);

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_B:    cond = 1'b1;
            OP_BZ:   cond = acc_zero;
            OP_BNZ:  cond = !acc_zero;
            OP_BGEZ: cond = !acc_neg;
            OP_BANZ: cond = ar_nonzero;
            OP_CALL: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        taken_next = taken_q;
        call_next  = is_call_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (!hold) begin
            case (state)
                RUN: begin
                    case (op)
                        OP_NONE: pc_next = pc_inc;
                        OP_RET: begin
                            pc_next = stack[0];
                            pop     = 1'b1;
                        end
                        default: begin
                            taken_next = cond;
                            call_next  = (op == OP_CALL);
                            pc_next    = pc_inc;
                            state_next = TARGET;
                        end
                    endcase
                end
                TARGET: begin
                    // Return address is the word after the CALL's address word.
                    pc_next    = taken_q ? instr_word[PC_WIDTH-1:0] : pc_inc;
                    push       = is_call_q;
                    state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pc        <= '0;
            taken_q   <= 1'b0;
            is_call_q <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            taken_q   <= taken_next;
            is_call_q <= call_next;
        end
    end

    // Push drops the oldest entry when full; pop copies the bottom entry upward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            depth     <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (push) begin
            for (int i = 1; i < STACK_DEPTH; i++) stack[i] <= stack[i-1];
            stack[0] <= pc_inc;
            if (depth == DEPTH_W'(STACK_DEPTH)) stack_ovf <= 1'b1;
            else depth <= depth + DEPTH_W'(1);
        end else if (pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) stack[i] <= stack[i+1];
            if (depth == '0) stack_unf <= 1'b1;
            else depth <= depth - DEPTH_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario queues the expected
// pc/exec_valid/flags per cycle and compares them one cycle later.
module tb_pc_sequencer;

    localparam logic [2:0] OP_NONE = 3'd0, OP_B = 3'd1, OP_BZ = 3'd2, OP_BNZ = 3'd3,
                           OP_BGEZ = 3'd4, OP_BANZ = 3'd5, OP_CALL = 3'd6, OP_RET = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic [15:0] instr_word = '0;
    logic [2:0]  branch_op = OP_NONE;
    logic        acc_zero = 1'b0, acc_neg = 1'b0, ar_nonzero = 1'b0;
    logic [11:0] pc;
    logic        exec_valid, stack_ovf, stack_unf;

    typedef struct {
        logic [11:0] pc;
        logic        ev;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .instr_word (instr_word),
        .branch_op  (branch_op),
        .acc_zero   (acc_zero),
        .acc_neg    (acc_neg),
        .ar_nonzero (ar_nonzero),
        .pc         (pc),
        .exec_valid (exec_valid),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] word,
                         input logic az, input logic an, input logic arnz, input logic hd);
        branch_op  = op;
        instr_word = word;
        acc_zero   = az;
        acc_neg    = an;
        ar_nonzero = arnz;
        hold       = hd;
    endtask

    task automatic expect_out(input logic [11:0] p, input logic ev, input logic ovf,
                              input logic unf, input string tag);
        exp_t e;
        e.pc = p; e.ev = ev; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic go_to(input int addr);
        reset = 1'b1;
        drive(OP_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (addr / 2) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        string tag;
        reset = 1'b1;
        drive(OP_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        expect_out(12'h000, 1'b1, 1'b0, 1'b0, "reset_state");
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                expect_out(12'(2 * i), 1'b1, 1'b0, 1'b0, $sformatf("seq_pc%0d", i));
                tick();
            end else begin
                @(negedge clk);
            end
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
            if (i == 0) reset = 1'b0;
        end
    endtask

    task automatic test_branch_taken();
        exp_t e;
        string tag;
        logic [2:0]  ops [2];
        logic [15:0] words [2];
        go_to(12'h010);
        ops   = '{OP_B, OP_RET};
        words = '{16'h0000, 16'h00A4};
        for (int i = 0; i < 2; i++) begin
            drive(ops[i], words[i], 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) expect_out(12'h012, 1'b0, 1'b0, 1'b0, "b_addr_word");
            else        expect_out(12'h0A4, 1'b1, 1'b0, 1'b0, "b_target");
            tick();
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
        end
    endtask

    // Flags are inverted during the address-word cycle to prove they are only
    // sampled on the opcode cycle. A final B to 0xFFE exercises PC wrap.
    task automatic test_conditional();
        exp_t e;
        string tag;
        logic [2:0]  ops [9];
        logic        az [9], an [9], ar [9], tk [9];
        logic [11:0] pcv, tgt;
        go_to(12'h020);
        pcv = 12'h020;
        ops = '{OP_BZ, OP_BZ, OP_BNZ, OP_BNZ, OP_BGEZ, OP_BGEZ, OP_BANZ, OP_BANZ, OP_B};
        az  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        an  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ar  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tk  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 20; i++) begin
            int k = i / 2;
            if (i == 18) begin
                drive(OP_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                expect_out(12'h000, 1'b1, 1'b0, 1'b0, "pc_wrap");
                pcv = 12'h000;
            end else if (i == 19) begin
                drive(OP_NONE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                expect_out(12'h002, 1'b1, 1'b0, 1'b0, "after_wrap");
            end else if (i % 2 == 0) begin
                drive(ops[k], 16'h0, az[k], an[k], ar[k], 1'b0);
                expect_out(pcv + 12'h002, 1'b0, 1'b0, 1'b0, $sformatf("cond%0d_addr", k));
            end else begin
                tgt = (k == 8) ? 12'hFFE : 12'h300 + 12'(16 * k);
                drive(OP_NONE, {4'h0, tgt}, ~az[k], ~an[k], ~ar[k], 1'b0);
                pcv = tk[k] ? tgt : pcv + 12'h004;
                expect_out(pcv, 1'b1, 1'b0, 1'b0, $sformatf("cond%0d_next", k));
            end
            tick();
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
        end
    endtask

    task automatic test_call_ret();
        exp_t e;
        string tag;
        logic [2:0]  ops [4];
        logic [15:0] words [4];
        go_to(12'h040);
        ops   = '{OP_CALL, OP_NONE, OP_RET, OP_RET};
        words = '{16'h0000, 16'h0200, 16'h0000, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], words[i], 1'b0, 1'b0, 1'b0, 1'b0);
            case (i)
                0: expect_out(12'h042, 1'b0, 1'b0, 1'b0, "call_addr");
                1: expect_out(12'h200, 1'b1, 1'b0, 1'b0, "call_target");
                2: expect_out(12'h044, 1'b1, 1'b0, 1'b0, "ret_addr");
                default: expect_out(12'h000, 1'b1, 1'b0, 1'b1, "ret_empty");
            endcase
            tick();
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
        end
    endtask

    // Five nested CALLs into a 4-deep stack, then five RETs: the oldest return
    // address is lost, the bottom entry repeats, and the pop at depth 0 flags.
    task automatic test_overflow();
        exp_t e;
        string tag;
        logic [11:0] rets [5];
        go_to(0);
        rets = '{12'h404, 12'h304, 12'h204, 12'h104, 12'h104};
        for (int i = 0; i < 15; i++) begin
            if (i < 10) begin
                int k = i / 2;
                if (i % 2 == 0) begin
                    drive(OP_CALL, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'(k * 256 + 2), 1'b0, k == 5, 1'b0, $sformatf("ncall%0d_addr", k));
                end else begin
                    drive(OP_NONE, 16'((k + 1) * 256), 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'((k + 1) * 256), 1'b1, k == 4, 1'b0, $sformatf("ncall%0d_push", k));
                end
            end else begin
                drive(OP_RET, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                expect_out(rets[i-10], 1'b1, 1'b1, i == 14, $sformatf("nret%0d", i - 10));
            end
            tick();
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
        end
    endtask

    task automatic test_hold_reset();
        exp_t e;
        string tag;
        go_to(12'h010);
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin
                    drive(OP_B, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'h012, 1'b0, 1'b0, 1'b0, "hold_enter");
                end
                1, 2, 3: begin
                    drive(OP_RET, 16'h00A4, 1'b0, 1'b0, 1'b0, 1'b1);
                    expect_out(12'h012, 1'b0, 1'b0, 1'b0, $sformatf("hold%0d", i));
                end
                4: begin
                    drive(OP_NONE, 16'h00A4, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'h0A4, 1'b1, 1'b0, 1'b0, "hold_release");
                end
                5: begin
                    drive(OP_RET, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
                    expect_out(12'h0A4, 1'b1, 1'b0, 1'b0, "hold_run_ret");
                end
                6: begin
                    drive(OP_B, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'h0A6, 1'b0, 1'b0, 1'b0, "b_before_reset");
                end
                7: begin
                    drive(OP_NONE, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'h000, 1'b1, 1'b0, 1'b0, "async_reset");
                end
                default: begin
                    drive(OP_NONE, 16'h0555, 1'b0, 1'b0, 1'b0, 1'b0);
                    expect_out(12'h002, 1'b1, 1'b0, 1'b0, "after_reset");
                end
            endcase
            if (i == 7) begin
                #2;
                reset = 1'b1;
                #1;
            end else begin
                tick();
            end
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            if ({pc, exec_valid, stack_ovf, stack_unf} !== {e.pc, e.ev, e.ovf, e.unf})
                $display("[TB] FAIL %s: got pc=%03h ev=%0b ovf=%0b unf=%0b, want pc=%03h ev=%0b ovf=%0b unf=%0b",
                         tag, pc, exec_valid, stack_ovf, stack_unf, e.pc, e.ev, e.ovf, e.unf);
            else passed++;
            if (i == 7) begin
                @(negedge clk);
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        $display("[TB] pc_sequencer bench start");
        test_reset();
        test_branch_taken();
        test_conditional();
        test_call_ret();
        test_overflow();
        test_hold_reset();
        checks++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
